// File: rtl/mem_port_if.sv
// Request, response and ram-side signals of mem_port bundled into one interface.
// slave: seen by mem_port. master: seen by the CPU datapath / ram side.
interface mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_din, ram_re, ram_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_din, ram_re, ram_we
  );
endinterface

// File: rtl/mem_port.sv
// mem_port: byte/half/word load-store sequencer in front of a word-addressed ram.
// Sub-word stores are read-modify-write. Loads extract and extend the addressed lane.
// Optional feature: define MEM_PORT_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses with resp_err instead of silently aligning them.
module mem_port (
  input  logic       clk,
  input  logic       rst_n,
  mem_port_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
  logic        err_q, err_d;
`endif

  logic        req_misal;
  logic [31:0] load_ext;
  logic [31:0] wr_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Misalignment of the incoming request; never flagged when trapping is disabled.
`ifdef MEM_PORT_MISALIGN_TRAP_EN
  always_comb begin
    req_misal = 1'b0;
    if (bus.req_size == 2'b01) req_misal = bus.req_addr[0];
    else if (bus.req_size[1])  req_misal = (bus.req_addr[1:0] != 2'b00);
  end
`else
  assign req_misal = 1'b0;
`endif

  // Lane extraction and extension from the ram word arriving in CAP.
  always_comb begin
    ld_byte  = bus.ram_dout[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = addr_q[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
    load_ext = bus.ram_dout;
    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = bus.ram_dout;
    endcase
  end

  // Write word: full store data, or the captured word with one lane replaced.
  always_comb begin
    wr_word = word_q;
    unique case (size_q)
      2'b00: wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
        else           wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
          err_d   = req_misal;
`endif
          if (req_misal) begin
            rdata_d = 32'b0;
            state_d = StResp;
          end else if (!bus.req_we || !bus.req_size[1]) begin
            state_d = StRd;
          end else begin
            state_d = StWr;
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        word_d = bus.ram_dout;
        if (!we_q) begin
          rdata_d = load_ext;
          state_d = StResp;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        rdata_d = 32'b0;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      word_q  <= 32'b0;
      rdata_q <= 32'b0;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Moore outputs decoded from state and request registers.
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.ram_re     = (state_q == StRd);
    bus.ram_we     = (state_q == StWr);
    bus.ram_addr   = {2'b00, addr_q[31:2]};
    bus.ram_din    = (state_q == StWr) ? wr_word : 32'b0;
    bus.resp_valid = (state_q == StResp);
    bus.resp_rdata = rdata_q;
`ifdef MEM_PORT_MISALIGN_TRAP_EN
    bus.resp_err   = (state_q == StResp) && err_q;
`else
    bus.resp_err   = 1'b0;
`endif
  end

endmodule
